seg_scan: RTL
=============

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (1..16).
REQ-002 Parameter DEAD_CYCLES, default 16, clocks per digit slot with all anodes off (ghosting guard, >=1).
REQ-003 Parameter HOLD_CYCLES, default 4096, clocks per digit slot with the selected anode on (>=1).
REQ-004 Parameter BLINK_FRAMES, default 64, frames per blink half-period (>=1).
REQ-005 Parameter ACTIVE_LOW, default 0, 1 inverts both segs_out and an_out.
REQ-006 clk  input  1  single clock, all logic rising-edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 enable  input  1  1 = scanning, 0 = display dark.
REQ-009 load  input  1  one-cycle strobe capturing codes/dp_mask/blink_mask.
REQ-010 codes  input  5*NUM_DIGITS  digit i code in bits [5i+4:5i].
REQ-011 dp_mask  input  NUM_DIGITS  decimal point per digit.
REQ-012 blink_mask  input  NUM_DIGITS  blink enable per digit.
REQ-013 segs_out  output  8  bit7 = dp, bits6..0 = g..a.
REQ-014 an_out  output  NUM_DIGITS  one-hot anode select, bit i = digit i.
REQ-015 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-016 Code table (active-high, bits6..0): 0..9 standard, 10 A=0x77, 11 b=0x7C, 12 C=0x39, 13 d=0x5E, 14 *=0x76, 15 #=0x49, 16 -=0x40, 17..31 all off.
REQ-017 Off level = 0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1; applies to every segment and anode bit.
REQ-018 load captures all three inputs into a pending register set and sets pend flag in the same edge; a second load before application overwrites pending.
REQ-019 Pending set is copied to the active set at a frame boundary (REQ-024) or on the next edge when state is IDLE; pend clears on copy; load on the copy cycle wins (pend stays set with new data).
REQ-020 FSM states IDLE, BLANK, SHOW; IDLE -> BLANK when enable=1, idx=0, slot counter=0.
REQ-021 BLANK: an_out all off, segs_out driven with digit idx pattern; after DEAD_CYCLES clocks -> SHOW.
REQ-022 SHOW: an_out bit idx on, others off; after HOLD_CYCLES clocks -> BLANK with idx+1.
REQ-023 Digit slot length = DEAD_CYCLES + HOLD_CYCLES clocks exactly; frame = NUM_DIGITS slots.
REQ-024 idx wraps NUM_DIGITS-1 -> 0 at the end of the last SHOW; that edge is the frame boundary: frame_done=1 for one cycle, blink frame counter increments.
REQ-025 Blink phase toggles when frame counter reaches BLINK_FRAMES-1 (counter then clears); phase=1 forces segs_out off (dp included) for digits with active blink_mask set; anodes unaffected.
REQ-026 segs_out bit7 = active dp_mask[idx] unless blanked by blink.
REQ-027 enable=0 in any state -> IDLE on next edge; outputs off level; idx, slot counter, blink counter and phase reset to 0.
REQ-028 All outputs registered; segs_out/an_out reflect state/idx one clock after the transition edge.

Reset
REQ-029 rst=1 at an edge: state IDLE, idx 0, counters 0, phase 0, pend 0, active/pending codes all 31, masks 0.
REQ-030 rst=1: segs_out and an_out off level, frame_done 0; rst overrides load and enable, including mid-frame.

Verification
REQ-031 ND=4, DEAD=2, HOLD=6, codes={3,2,1,0}, load, enable -> per 8-clk slot 2 clk an_out=0 then an_out=0001/0010/0100/1000 with segs 0x3F,0x06,0x5B,0x4F; frame_done every 32 clk.
REQ-032 load codes=all 8 mid-frame -> old values until frame_done, 0x7F on all digits from next frame.
REQ-033 blink_mask=0010, BLINK_FRAMES=2 -> digit1 segs 0x00 during frames 2-3, visible frames 0-1, 4-5; other digits unaffected.
REQ-034 codes digit0=17, dp_mask=0001 -> digit0 segs 0x80; code 16 -> 0x40.
REQ-035 ACTIVE_LOW=1, digit0=0 -> segs 0xC0, an_out 1110 in SHOW, 1111 in BLANK/IDLE.
REQ-036 rst or enable=0 asserted during SHOW of idx 2 -> next edge outputs off, restart from idx 0 after release/enable.

Source files
------------

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: per-digit dead-time/hold slots, blink and
// frame-synchronous update of the displayed codes.
module seg_scan #(
   parameter int NUM_DIGITS   = 4,
   parameter int DEAD_CYCLES  = 16,
   parameter int HOLD_CYCLES  = 4096,
   parameter int BLINK_FRAMES = 64,
   parameter bit ACTIVE_LOW   = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    load,
   input  logic [5*NUM_DIGITS-1:0] codes,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [7:0]              segs_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);

   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int SLOT_MAX = (DEAD_CYCLES > HOLD_CYCLES) ? DEAD_CYCLES : HOLD_CYCLES;
   localparam int CW       = $clog2(SLOT_MAX + 1);
   localparam int FW       = $clog2(BLINK_FRAMES + 1);

   localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]         DEAD_LAST  = CW'(DEAD_CYCLES - 1);
   localparam logic [CW-1:0]         HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [FW-1:0]         BLINK_LAST = FW'(BLINK_FRAMES - 1);
   localparam logic [7:0]            SEG_OFF    = {8{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t                  state, state_nxt;
   logic [IW-1:0]           idx;
   logic [CW-1:0]           slot_cnt;
   logic [FW-1:0]           frame_cnt;
   logic                    phase;
   logic                    pend;
   logic [5*NUM_DIGITS-1:0] act_codes, pnd_codes;
   logic [NUM_DIGITS-1:0]   act_dp, pnd_dp, act_blink, pnd_blink;
   logic                    blank_end, show_end, frame_end, apply;
   logic [7:0]              digit_p0, segs_p0;
   logic [NUM_DIGITS-1:0]   an_p0;

   function automatic logic [6:0] seg_decode(input logic [4:0] code);
      case (code)
         5'd0:    seg_decode = 7'h3F;
         5'd1:    seg_decode = 7'h06;
         5'd2:    seg_decode = 7'h5B;
         5'd3:    seg_decode = 7'h4F;
         5'd4:    seg_decode = 7'h66;
         5'd5:    seg_decode = 7'h6D;
         5'd6:    seg_decode = 7'h7D;
         5'd7:    seg_decode = 7'h07;
         5'd8:    seg_decode = 7'h7F;
         5'd9:    seg_decode = 7'h6F;
         5'd10:   seg_decode = 7'h77;
         5'd11:   seg_decode = 7'h7C;
         5'd12:   seg_decode = 7'h39;
         5'd13:   seg_decode = 7'h5E;
         5'd14:   seg_decode = 7'h76;
         5'd15:   seg_decode = 7'h49;
         5'd16:   seg_decode = 7'h40;
         default: seg_decode = 7'h00;
      endcase
   endfunction

   assign blank_end = (state == BLANK) && (slot_cnt == DEAD_LAST);
   assign show_end  = (state == SHOW) && (slot_cnt == HOLD_LAST);
   assign frame_end = show_end && (idx == LAST_IDX);
   assign apply     = pend && (frame_end || (state == IDLE));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = BLANK;
            BLANK:   if (blank_end) state_nxt = SHOW;
            SHOW:    if (show_end) state_nxt = BLANK;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // slot/digit/blink counters; IDLE is only reachable through rst or enable=0
   always_ff @(posedge clk) begin
      if (rst || !enable || (state == IDLE)) begin
         idx       <= '0;
         slot_cnt  <= '0;
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else begin
         slot_cnt <= (blank_end || show_end) ? '0 : slot_cnt + 1'b1;
         if (show_end) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         if (frame_end) begin
            if (frame_cnt == BLINK_LAST) begin
               frame_cnt <= '0;
               phase     <= ~phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

   // a load on the copy cycle refills pending and keeps pend set
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= 1'b0;
         pnd_codes <= '1;
         pnd_dp    <= '0;
         pnd_blink <= '0;
         act_codes <= '1;
         act_dp    <= '0;
         act_blink <= '0;
      end else begin
         if (apply) begin
            act_codes <= pnd_codes;
            act_dp    <= pnd_dp;
            act_blink <= pnd_blink;
         end
         if (load) begin
            pnd_codes <= codes;
            pnd_dp    <= dp_mask;
            pnd_blink <= blink_mask;
            pend      <= 1'b1;
         end else if (apply) begin
            pend <= 1'b0;
         end
      end
   end

   always_comb begin
      segs_p0  = SEG_OFF;
      an_p0    = AN_OFF;
      digit_p0 = {act_dp[idx], seg_decode(act_codes[5*idx +: 5])};
      if (phase && act_blink[idx]) digit_p0 = 8'h00;
      case (state)
         BLANK: segs_p0 = digit_p0 ^ SEG_OFF;
         SHOW: begin
            segs_p0 = digit_p0 ^ SEG_OFF;
            an_p0   = (NUM_DIGITS'(1) << idx) ^ AN_OFF;
         end
         default: ;
      endcase
   end

   // output stage: one clock behind the state it shows, forced dark at once
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         segs_out   <= SEG_OFF;
         an_out     <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         segs_out   <= segs_p0;
         an_out     <= an_p0;
         frame_done <= frame_end;
      end
   end

endmodule
